// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared encodings for the multi-cycle RV32I control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // FSM state encodings
    localparam logic [3:0] C_ST_FETCH    = 4'd0;
    localparam logic [3:0] C_ST_DECODE   = 4'd1;
    localparam logic [3:0] C_ST_MEMADR   = 4'd2;
    localparam logic [3:0] C_ST_MEMREAD  = 4'd3;
    localparam logic [3:0] C_ST_MEMWB    = 4'd4;
    localparam logic [3:0] C_ST_MEMWRITE = 4'd5;
    localparam logic [3:0] C_ST_EXECR    = 4'd6;
    localparam logic [3:0] C_ST_EXECI    = 4'd7;
    localparam logic [3:0] C_ST_ALUWB    = 4'd8;
    localparam logic [3:0] C_ST_BRANCH   = 4'd9;
    localparam logic [3:0] C_ST_JAL      = 4'd10;

    localparam logic [2:0] C_ALU_ADD   = 3'b000;
    localparam logic [2:0] C_ALU_SUB   = 3'b001;
    localparam logic [2:0] C_ALU_AND   = 3'b010;
    localparam logic [2:0] C_ALU_OR    = 3'b011;
    localparam logic [2:0] C_ALU_XOR   = 3'b100;
    localparam logic [2:0] C_ALU_CMP   = 3'b101;
    localparam logic [2:0] C_ALU_SHIFT = 3'b110;

    // ALUOp handed from the FSM to the ALU decoder
    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] C_ALUOP_CMP   = 2'b11;

    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;

    localparam logic [1:0] C_SRCA_PC    = 2'b00;
    localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] C_SRCA_RS1   = 2'b10;

    localparam logic [1:0] C_SRCB_RS2   = 2'b00;
    localparam logic [1:0] C_SRCB_IMM   = 2'b01;
    localparam logic [1:0] C_SRCB_FOUR  = 2'b10;

    localparam logic [1:0] C_RES_ALUOUT = 2'b00;
    localparam logic [1:0] C_RES_MEM    = 2'b01;
    localparam logic [1:0] C_RES_ALU    = 2'b10;

    localparam logic [2:0] C_IMM_I = 3'b000;
    localparam logic [2:0] C_IMM_S = 3'b001;
    localparam logic [2:0] C_IMM_B = 3'b010;
    localparam logic [2:0] C_IMM_J = 3'b011;

    function automatic logic [2:0] imm_decode(input logic [6:0] op);
        case (op)
            C_OP_STORE:  imm_decode = C_IMM_S;
            C_OP_BRANCH: imm_decode = C_IMM_B;
            C_OP_JAL:    imm_decode = C_IMM_J;
            default:     imm_decode = C_IMM_I;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps ALUOp plus instruction funct fields onto ALU controls.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op5,
    output logic [2:0] alu_control,
    output logic [2:0] alu_funct3,
    output logic       alu_funct7_5
);

    always_comb begin
        alu_control  = C_ALU_ADD;
        alu_funct3   = 3'b000;
        alu_funct7_5 = 1'b0;
        case (alu_op)
            C_ALUOP_SUB: alu_control = C_ALU_SUB;
            C_ALUOP_CMP: begin
                // Branch compares reuse slt/sltu: funct3[1] selects unsigned
                alu_control = C_ALU_CMP;
                alu_funct3  = {2'b01, funct3[1]};
            end
            C_ALUOP_FUNCT: begin
                alu_funct3 = funct3;
                case (funct3)
                    3'b000:         alu_control = (op5 & funct7_5) ? C_ALU_SUB : C_ALU_ADD;
                    3'b001, 3'b101: begin
                        alu_control  = C_ALU_SHIFT;
                        alu_funct7_5 = funct7_5;
                    end
                    3'b010, 3'b011: alu_control = C_ALU_CMP;
                    3'b100:         alu_control = C_ALU_XOR;
                    3'b110:         alu_control = C_ALU_OR;
                    default:        alu_control = C_ALU_AND;
                endcase
            end
            default: alu_control = C_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_unit
// Description : Multi-cycle RV32I control FSM sharing one memory port.
//               Define BRANCH_CMP_EN to add blt/bge/bltu/bgeu support.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control,
    output logic [2:0] alu_funct3,
    output logic       alu_funct7_5,
    output logic       illegal_instr
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_br_legal;
    logic       w_br_take;
    logic       w_br_cmp;
    logic       w_op_legal;
    logic [1:0] w_alu_op;
    logic       w_pc_write;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_illegal;

`ifdef BRANCH_CMP_EN
    assign w_br_legal = (funct3[2:1] != 2'b01);
    assign w_br_cmp   = funct3[2];
    // bge/bgeu (funct3[0]=1) take on zero, like beq; blt/bltu invert it
    assign w_br_take  = funct3[2] ? (funct3[0] ? alu_zero : ~alu_zero)
                                  : (funct3[0] ? ~alu_zero : alu_zero);
`else
    assign w_br_legal = (funct3[2:1] == 2'b00);
    assign w_br_cmp   = 1'b0;
    assign w_br_take  = funct3[0] ? ~alu_zero : alu_zero;
`endif

    always_comb begin
        case (opcode)
            C_OP_LOAD, C_OP_STORE, C_OP_RTYPE,
            C_OP_ITYPE, C_OP_JAL:  w_op_legal = 1'b1;
            C_OP_BRANCH:           w_op_legal = w_br_legal;
            default:               w_op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RESET_STATE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_ST_FETCH:    w_next_state = mem_ready ? C_ST_DECODE : C_ST_FETCH;
            C_ST_DECODE: begin
                w_next_state = C_ST_FETCH;
                if (w_op_legal) begin
                    case (opcode)
                        C_OP_LOAD, C_OP_STORE: w_next_state = C_ST_MEMADR;
                        C_OP_RTYPE:            w_next_state = C_ST_EXECR;
                        C_OP_ITYPE:            w_next_state = C_ST_EXECI;
                        C_OP_BRANCH:           w_next_state = C_ST_BRANCH;
                        default:               w_next_state = C_ST_JAL;
                    endcase
                end
            end
            C_ST_MEMADR:   w_next_state = opcode[5] ? C_ST_MEMWRITE : C_ST_MEMREAD;
            C_ST_MEMREAD:  w_next_state = mem_ready ? C_ST_MEMWB : C_ST_MEMREAD;
            C_ST_MEMWRITE: w_next_state = mem_ready ? C_ST_FETCH : C_ST_MEMWRITE;
            C_ST_EXECR,
            C_ST_EXECI,
            C_ST_JAL:      w_next_state = (r_state == C_ST_JAL) ? C_ST_ALUWB : C_ST_ALUWB;
            default:       w_next_state = C_ST_FETCH;
        endcase
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        adr_src     = 1'b0;
        result_src  = C_RES_ALUOUT;
        alu_src_a   = C_SRCA_PC;
        alu_src_b   = C_SRCB_RS2;
        w_alu_op    = C_ALUOP_ADD;
        case (r_state)
            C_ST_FETCH: begin
                alu_src_b  = C_SRCB_FOUR;
                result_src = C_RES_ALU;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            C_ST_DECODE: begin
                alu_src_a = C_SRCA_OLDPC;
                alu_src_b = C_SRCB_IMM;
                w_illegal = ~w_op_legal;
            end
            C_ST_MEMADR: begin
                alu_src_a = C_SRCA_RS1;
                alu_src_b = C_SRCB_IMM;
            end
            C_ST_MEMREAD:  adr_src = 1'b1;
            C_ST_MEMWB: begin
                result_src  = C_RES_MEM;
                w_reg_write = 1'b1;
            end
            C_ST_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
            end
            C_ST_EXECR: begin
                alu_src_a = C_SRCA_RS1;
                w_alu_op  = C_ALUOP_FUNCT;
            end
            C_ST_EXECI: begin
                alu_src_a = C_SRCA_RS1;
                alu_src_b = C_SRCB_IMM;
                w_alu_op  = C_ALUOP_FUNCT;
            end
            C_ST_ALUWB:    w_reg_write = 1'b1;
            C_ST_BRANCH: begin
                alu_src_a  = C_SRCA_RS1;
                w_alu_op   = w_br_cmp ? C_ALUOP_CMP : C_ALUOP_SUB;
                w_pc_write = w_br_take;
            end
            C_ST_JAL: begin
                alu_src_a  = C_SRCA_OLDPC;
                alu_src_b  = C_SRCB_FOUR;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are forced low while rst is held so nothing writes during reset
    assign pc_write      = w_pc_write  & ~rst;
    assign ir_write      = w_ir_write  & ~rst;
    assign mem_write     = w_mem_write & ~rst;
    assign reg_write     = w_reg_write & ~rst;
    assign illegal_instr = w_illegal   & ~rst;
    assign imm_src       = imm_decode(opcode);

    alu_decoder u_alu_decoder (
        .alu_op       (w_alu_op),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .op5          (opcode[5]),
        .alu_control  (alu_control),
        .alu_funct3   (alu_funct3),
        .alu_funct7_5 (alu_funct7_5)
    );

endmodule
`default_nettype wire

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle RV32I control FSM, the initiator side of the existing ALU interface.
- Drives the ALU's ALUControl, funct3 and funct7_5 inputs, consumes its Zero flag, and sequences the PC, instruction register, memory and register-file enables.
- Replaces single-cycle combinational control in the next (multi-cycle) core; shares one memory port for instruction fetch and data access.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- alu_zero  in  1  Zero flag from ALU
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  PC register load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register and OldPC load enable
- result_src  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 data
- alu_src_b  out  2  00 = rs2 data, 01 = immediate, 10 = constant 4
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J
- reg_write  out  1  register file write enable
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 compare, 110 shift
- alu_funct3  out  3  funct3 presented to ALU
- alu_funct7_5  out  1  funct7_5 presented to ALU
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode or funct3

Behaviour:
- Reset:
  - clk and rst as named; rst asynchronous, active-high.
  - State is forced to FETCH immediately.
  - While rst is high, all enables are 0: pc_write, ir_write, mem_write, reg_write, illegal_instr. Other outputs take FETCH values.
  - Reset asserted mid-instruction aborts it; no partial write occurs after assertion.
- Outputs are Moore-decoded from state. Exceptions: pc_write and ir_write in FETCH, and pc_write in BRANCH.
- imm_src is decoded combinationally from opcode in every state.
- States and outputs; unlisted enables are 0:
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10; ir_write = pc_write = mem_ready. Next: DECODE if mem_ready, else FETCH.
  - DECODE: alu_src_a=01, alu_src_b=01, add (branch/jump target into ALUOut). Next by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - any other opcode: illegal_instr=1, next FETCH
  - MEMADR: alu_src_a=10, alu_src_b=01, add. Next: MEMREAD if opcode[5]=0, else MEMWRITE.
  - MEMREAD: adr_src=1. Next: MEMWB when mem_ready, else hold.
  - MEMWB: result_src=01, reg_write=1. Next: FETCH.
  - MEMWRITE: adr_src=1, mem_write=1, held until mem_ready. Next: FETCH when mem_ready.
  - EXECR: alu_src_a=10, alu_src_b=00, funct decode. Next: ALUWB.
  - EXECI: alu_src_a=10, alu_src_b=01, funct decode. Next: ALUWB.
  - ALUWB: result_src=00, reg_write=1. Next: FETCH.
  - BRANCH: alu_src_a=10, alu_src_b=00, result_src=00, sub. pc_write = alu_zero for beq (000), ~alu_zero for bne (001). Next: FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Next: ALUWB.
- Funct decode, by funct3:
  - 000: sub if opcode[5] & funct7_5, else add
  - 001 and 101: shift (110)
  - 010 and 011: compare (101)
  - 100: xor
  - 110: or
  - 111: and
- alu_funct3 = funct3 in execute states. alu_funct7_5 = funct7_5 for shifts, 0 otherwise.
- Latency with mem_ready tied to 1, counted in cycles from FETCH:
  - R/I-type: 4
  - lw: 5
  - sw: 4
  - branch: 3
  - jal: 4
- Each mem_ready=0 cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- Branch with funct3 outside 000/001 (feature disabled): illegal_instr pulses in DECODE; next state FETCH; no PC update.

Optional Feature:
- Macro: BRANCH_CMP_EN.
- Defined:
  - BRANCH also supports blt (100), bge (101), bltu (110) and bgeu (111).
  - alu_control=101; alu_funct3=010 for signed and 011 for unsigned.
  - pc_write = ~alu_zero for blt/bltu, and alu_zero for bge/bgeu.
- Undefined: those funct3 values are illegal as stated above.

Decomposition:
- Shared package mc_ctrl_pkg:
  - 4-bit state encodings FETCH..JAL
  - ALU control codes 000–110
  - opcode constants
  - alu_src_a, alu_src_b, result_src and imm_src select codes
- Sub-module alu_decoder: combinational; ALUOp (add/sub/funct), funct3, funct7_5 and opcode[5] → alu_control, alu_funct3, alu_funct7_5.

Test Plan:
- Reset: rst pulsed mid-MEMWRITE, asynchronous to clk → state FETCH and mem_write=0 within the same cycle; no enables high while rst=1.
- add x3,x1,x2 (opcode 0110011, funct3 000, f7_5=0), mem_ready=1:
  - states FETCH, DECODE, EXECR, ALUWB
  - alu_control=000 in EXECR; reg_write=1 only in cycle 4
  - sub variant (f7_5=1) → alu_control=001
- lw with mem_ready low for 2 cycles in MEMREAD → total 7 cycles; reg_write=1 with result_src=01 exactly once.
- beq:
  - alu_zero=1 → pc_write=1 in BRANCH
  - alu_zero=0 → pc_write=0
  - bne (funct3 001) with alu_zero=0 → pc_write=1
- srai (0010011, funct3 101, f7_5=1) → alu_control=110, alu_funct7_5=1, alu_funct3=101.
- Opcode 1110011 → illegal_instr one-cycle pulse in DECODE, return to FETCH, no writes. blt with BRANCH_CMP_EN undefined → same result; with it defined → alu_funct3=010, pc_write=~alu_zero.
